regfile_bypass: RTL and testbench

REGFILE_BYPASS -- requirements
Module: regfile_bypass

---
 rtl/regfile_bypass.sv | 91 +++++++++
 tb/tb_regfile_bypass.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass.sv
// 32x32 register file with EX/MEM/WB operand forwarding and load-use stall detection.
// Two independent combinational read ports; a single WB write port commits on the rising clock edge.
module regfile_bypass (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] wb_to_rf_bus,
    input  logic [37:0] mem_to_id_bus,
    input  logic [38:0] ex_to_id_bus,
    input  logic        re1,
    input  logic        re2,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    output logic        stallreq_load
);

    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        ex_is_load;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;

    assign {wb_we, wb_waddr, wb_wdata}              = wb_to_rf_bus;
    assign {mem_we, mem_waddr, mem_wdata}           = mem_to_id_bus;
    assign {ex_is_load, ex_we, ex_waddr, ex_wdata}  = ex_to_id_bus;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // EX data is skipped while it is a load: the value only exists after MEM.
    function automatic logic [31:0] resolve(
        input logic        re,
        input logic [4:0]  raddr,
        input logic [31:0] arr_val
    );
        logic [31:0] r;
        if (!re || (raddr == 5'd0)) begin
            r = 32'd0;
        end else if (ex_we && !ex_is_load && (ex_waddr == raddr)) begin
            r = ex_wdata;
        end else if (mem_we && (mem_waddr == raddr)) begin
            r = mem_wdata;
        end else if (wb_we && (wb_waddr == raddr)) begin
            r = wb_wdata;
        end else begin
            r = arr_val;
        end
        return r;
    endfunction

    // Next-state array: apply the WB write, register 0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_waddr != 5'd0)) begin
            regs_d[wb_waddr] = wb_wdata;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = 32'd0;
    end

    // Array storage; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read-port resolution and load-use stall detection.
    always_comb begin
        rdata1        = resolve(re1, raddr1, regs_q[raddr1]);
        rdata2        = resolve(re2, raddr2, regs_q[raddr2]);
        stallreq_load = 1'b0;
        if (ex_is_load && ex_we && (ex_waddr != 5'd0)) begin
            stallreq_load = (re1 && (raddr1 == ex_waddr)) || (re2 && (raddr2 == ex_waddr));
        end else begin
            stallreq_load = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_bypass;

    logic        clk;
    logic        rst;
    logic [37:0] wb_to_rf_bus;
    logic [37:0] mem_to_id_bus;
    logic [38:0] ex_to_id_bus;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        stallreq_load;

    int tests_run;
    int tests_failed;
    logic [31:0] model [32];

    regfile_bypass dut (
        .clk           (clk),
        .rst           (rst),
        .wb_to_rf_bus  (wb_to_rf_bus),
        .mem_to_id_bus (mem_to_id_bus),
        .ex_to_id_bus  (ex_to_id_bus),
        .re1           (re1),
        .re2           (re2),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .rdata1        (rdata1),
        .rdata2        (rdata2),
        .stallreq_load (stallreq_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: newest in-flight producer wins, loads in EX are not yet usable.
    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
        if (ex_to_id_bus[37] && !ex_to_id_bus[38] && ex_to_id_bus[36:32] == a) return ex_to_id_bus[31:0];
        if (mem_to_id_bus[37] && mem_to_id_bus[36:32] == a) return mem_to_id_bus[31:0];
        if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] == a) return wb_to_rf_bus[31:0];
        return model[a];
    endfunction

    function automatic logic exp_stall();
        logic [4:0] w;
        w = ex_to_id_bus[36:32];
        return ex_to_id_bus[38] && ex_to_id_bus[37] && w != 5'd0 &&
               ((re1 && raddr1 == w) || (re2 && raddr2 == w));
    endfunction

    // Advance one clock edge, updating the model with what the edge commits.
    task automatic step();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (wb_to_rf_bus[37] && wb_to_rf_bus[36:32] != 5'd0) begin
            model[wb_to_rf_bus[36:32]] = wb_to_rf_bus[31:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        wb_to_rf_bus = 38'd0;
        mem_to_id_bus = 38'd0;
        ex_to_id_bus = 39'd0;
        re1 = 1'b0; re2 = 1'b0;
        raddr1 = 5'd0; raddr2 = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd1; raddr2 = 5'd31;
        #1;
        tests_run++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || stallreq_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rdata1=%h rdata2=%h stall=%b expected 0 0 0", rdata1, rdata2, stallreq_load);
        end
    endtask

    task automatic test_array_write();
        idle_inputs();
        wb_to_rf_bus = {1'b1, 5'd5, 32'h12345678};
        step();
        wb_to_rf_bus = 38'd0;
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        tests_run++;
        if (rdata1 !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL array_write: rdata1=%h expected %h", rdata1, 32'h12345678);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        wb_to_rf_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
        step();
        wb_to_rf_bus = 38'd0;
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        tests_run++;
        if (rdata1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL zero_reg_read: rdata1=%h expected 0", rdata1);
        end
        ex_to_id_bus = {1'b0, 1'b1, 5'd0, 32'hAAAA0000};
        #1;
        tests_run++;
        if (rdata1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL zero_reg_ex_fwd: rdata1=%h expected 0", rdata1);
        end
        ex_to_id_bus = {1'b0, 1'b1, 5'd4, 32'hAAAA0000};
        re1 = 1'b0; raddr1 = 5'd4;
        #1;
        tests_run++;
        if (rdata1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL read_disabled: rdata1=%h expected 0", rdata1);
        end
    endtask

    task automatic test_priority();
        logic [31:0] exp_v [4];
        idle_inputs();
        wb_to_rf_bus = {1'b1, 5'd8, 32'hCAFE0008};
        step();
        exp_v[0] = 32'h1; exp_v[1] = 32'h2; exp_v[2] = 32'h3; exp_v[3] = 32'hCAFE0008;
        ex_to_id_bus  = {1'b0, 1'b1, 5'd8, 32'h1};
        mem_to_id_bus = {1'b1, 5'd8, 32'h2};
        wb_to_rf_bus  = {1'b1, 5'd8, 32'h3};
        re2 = 1'b1; raddr2 = 5'd8;
        for (int k = 0; k < 4; k++) begin
            #1;
            tests_run++;
            if (rdata2 !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL priority_stage%0d: rdata2=%h expected %h", k, rdata2, exp_v[k]);
            end
            if (k == 0) ex_to_id_bus = 39'd0;
            else if (k == 1) mem_to_id_bus = 38'd0;
            else wb_to_rf_bus = 38'd0;
        end
    endtask

    task automatic test_load_stall();
        idle_inputs();
        ex_to_id_bus = {1'b1, 1'b1, 5'd9, 32'h99};
        re1 = 1'b1; raddr1 = 5'd9;
        #1;
        tests_run++;
        if (stallreq_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_port1: stall=%b expected 1", stallreq_load);
        end
        re1 = 1'b0;
        #1;
        tests_run++;
        if (stallreq_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_re_off: stall=%b expected 0", stallreq_load);
        end
        re2 = 1'b1; raddr2 = 5'd9;
        #1;
        tests_run++;
        if (stallreq_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_port2: stall=%b expected 1", stallreq_load);
        end
        re2 = 1'b0;
        re1 = 1'b1; raddr1 = 5'd0;
        ex_to_id_bus = {1'b1, 1'b1, 5'd0, 32'h99};
        #1;
        tests_run++;
        if (stallreq_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_addr0: stall=%b expected 0", stallreq_load);
        end
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        wb_to_rf_bus = {1'b1, 5'd3, 32'hDEADBEEF};
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        tests_run++;
        if (rdata1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wb_bypass_same_cycle: rdata1=%h expected %h", rdata1, 32'hDEADBEEF);
        end
        step();
        wb_to_rf_bus = 38'd0;
        #1;
        tests_run++;
        if (rdata1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL wb_bypass_committed: rdata1=%h expected %h", rdata1, 32'hDEADBEEF);
        end
    endtask

    task automatic test_reset_clear();
        idle_inputs();
        for (int r = 1; r < 32; r++) begin
            wb_to_rf_bus = {1'b1, r[4:0], 32'h1000_0000 | 32'(r)};
            step();
        end
        rst = 1'b1;
        wb_to_rf_bus = {1'b1, 5'd7, 32'h77777777};
        step();
        idle_inputs();
        re1 = 1'b1;
        for (int r = 0; r < 32; r++) begin
            raddr1 = r[4:0];
            #1;
            tests_run++;
            if (rdata1 !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_clear_reg%0d: rdata1=%h expected 0", r, rdata1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        es;
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 39) == 0);
            wb_to_rf_bus  = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            mem_to_id_bus = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            ex_to_id_bus  = {1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
            re1 = ($urandom_range(0, 7) != 0);
            re2 = ($urandom_range(0, 7) != 0);
            raddr1 = 5'($urandom_range(0, 7));
            raddr2 = 5'($urandom_range(0, 7));
            #1;
            e1 = exp_read(re1, raddr1);
            e2 = exp_read(re2, raddr2);
            es = exp_stall();
            tests_run++;
            if (stallreq_load !== es) begin
                tests_failed++;
                $display("FAIL rand_stall[%0d]: stall=%b expected %b", n, stallreq_load, es);
            end
            if (!es) begin
                tests_run++;
                if (rdata1 !== e1 || rdata2 !== e2) begin
                    tests_failed++;
                    $display("FAIL rand_read[%0d]: rdata1=%h rdata2=%h expected %h %h", n, rdata1, rdata2, e1, e2);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        idle_inputs();
        test_reset();
        test_array_write();
        test_zero_reg();
        test_priority();
        test_load_stall();
        test_wb_bypass();
        test_reset_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
